// File: rtl/stl_uart_host.sv
// STL UART host: serializes a 128-bit command into 16 UART bytes, then collects a 16-byte response.
// Optional STL_UART_HOST_TIMEOUT_CNT_EN adds a saturating timeout_count output.
module stl_uart_host #(
  parameter int PACKET_SIZE    = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [127:0] cmd_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [7:0]   tx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  input  logic [7:0]   rx_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_timeout,
  output logic         busy,
`ifdef STL_UART_HOST_TIMEOUT_CNT_EN
  output logic [7:0]   timeout_count,
`endif
  output logic [1:0]   debug_state
);

  // state | meaning
  // IDLE  | waiting for a command packet
  // SEND  | shifting command bytes out to the transmitter
  // RECV  | collecting response bytes, watching for silence
  // RSP   | holding the assembled response for the consumer

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [4:0]    LAST_BYTE = 5'(PACKET_SIZE - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2,
    RSP  = 2'd3
  } state_t;

  state_t         state, state_nxt;
  logic [4:0]     byte_cnt, byte_cnt_nxt;
  logic [TW-1:0]  to_cnt, to_cnt_nxt;
  logic [127:0]   shift_buf, shift_buf_nxt;
  logic           timeout_nxt, rsp_timeout_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      byte_cnt      <= '0;
      to_cnt        <= '0;
      shift_buf     <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state         <= state_nxt;
      byte_cnt      <= byte_cnt_nxt;
      to_cnt        <= to_cnt_nxt;
      shift_buf     <= shift_buf_nxt;
      rsp_timeout_q <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    byte_cnt_nxt  = byte_cnt;
    to_cnt_nxt    = to_cnt;
    shift_buf_nxt = shift_buf;
    timeout_nxt   = 1'b0;
    cmd_ready     = 1'b0;
    tx_valid      = 1'b0;
    rx_ready      = 1'b0;
    rsp_valid     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          shift_buf_nxt = cmd_data;
          byte_cnt_nxt  = '0;
          state_nxt     = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          shift_buf_nxt = {8'h00, shift_buf[127:8]};
          if (byte_cnt == LAST_BYTE) begin
            byte_cnt_nxt = '0;
            to_cnt_nxt   = '0;
            state_nxt    = RECV;
          end else begin
            byte_cnt_nxt = byte_cnt + 5'd1;
          end
        end
      end
      RECV: begin
        rx_ready = 1'b1;
        // a byte on the threshold cycle takes priority over the timeout
        if (rx_valid) begin
          shift_buf_nxt = {rx_data, shift_buf[127:8]};
          to_cnt_nxt    = '0;
          if (byte_cnt == LAST_BYTE) begin
            byte_cnt_nxt = '0;
            state_nxt    = RSP;
          end else begin
            byte_cnt_nxt = byte_cnt + 5'd1;
          end
        end else if (to_cnt == TO_LAST) begin
          timeout_nxt   = 1'b1;
          shift_buf_nxt = '0;
          byte_cnt_nxt  = '0;
          to_cnt_nxt    = '0;
          state_nxt     = IDLE;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
        end
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tx_data     = (state == SEND) ? shift_buf[7:0] : 8'h00;
  assign rsp_data    = (state == RSP) ? shift_buf : '0;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = (state != IDLE);
  assign debug_state = state;

`ifdef STL_UART_HOST_TIMEOUT_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_count <= 8'd0;
    end else if (timeout_nxt && (timeout_count != 8'hFF)) begin
      timeout_count <= timeout_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stl_uart_host.sv
// Self-checking bench for stl_uart_host: transaction-level scoreboard plus directed literal checks.
module tb_stl_uart_host;
  localparam int T = 8;

  logic         clk;
  logic         reset_n;
  logic         cmd_valid, cmd_ready;
  logic [127:0] cmd_data;
  logic         tx_valid, tx_ready;
  logic [7:0]   tx_data;
  logic         rx_valid, rx_ready;
  logic [7:0]   rx_data;
  logic         rsp_valid, rsp_ready;
  logic [127:0] rsp_data;
  logic         rsp_timeout, busy;
  logic [1:0]   debug_state;
`ifdef STL_UART_HOST_TIMEOUT_CNT_EN
  logic [7:0]   timeout_count;
`endif

  stl_uart_host #(.PACKET_SIZE(16), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .busy(busy),
`ifdef STL_UART_HOST_TIMEOUT_CNT_EN
    .timeout_count(timeout_count),
`endif
    .debug_state(debug_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // reference model: what must be happening, in terms of pending bytes and packet phase
  logic [7:0]   exp_tx[$];
  logic [7:0]   rx_got[$];
  logic [7:0]   tx_log[$];
  int           tx_hs_cyc[$];
  bit           m_idle = 1'b1;
  bit           m_collect = 1'b0;
  bit           m_rsp = 1'b0;
  bit           m_to_due = 1'b0;
  logic [127:0] m_rsp_data = '0;
  int           silent = 0;
  int           cyc = 0;
  int           to_pulses = 0;
  int           pulse_cyc = 0;
  int           last_rx_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      chk("reset_ctl", {cmd_ready, tx_valid, rx_ready, rsp_valid, rsp_timeout, busy, debug_state}, 8'b1000_0000);
      chk("reset_tx_data", tx_data, 8'h00);
      chk("reset_rsp_data", rsp_data, 128'h0);
      exp_tx.delete();
      rx_got.delete();
      m_idle = 1'b1; m_collect = 1'b0; m_rsp = 1'b0; m_to_due = 1'b0; silent = 0;
    end else begin
      chk("cmd_ready", cmd_ready, m_idle);
      chk("busy", busy, !m_idle);
      chk("tx_valid", tx_valid, exp_tx.size() != 0);
      chk("rx_ready", rx_ready, m_collect);
      chk("rsp_valid", rsp_valid, m_rsp);
      chk("rsp_timeout", rsp_timeout, m_to_due);
      if (tx_valid && exp_tx.size() != 0) chk("tx_data", tx_data, exp_tx[0]);
      if (m_rsp) chk("rsp_data", rsp_data, m_rsp_data);
      if (rsp_timeout) begin
        to_pulses++;
        pulse_cyc = cyc;
      end
      m_to_due = 1'b0;
      if (m_idle) begin
        if (cmd_valid) begin
          for (int i = 0; i < 16; i++) exp_tx.push_back(cmd_data[8*i +: 8]);
          m_idle = 1'b0;
        end
      end else if (exp_tx.size() != 0) begin
        if (tx_ready) begin
          tx_log.push_back(tx_data);
          tx_hs_cyc.push_back(cyc);
          void'(exp_tx.pop_front());
          if (exp_tx.size() == 0) begin
            m_collect = 1'b1;
            silent = 0;
            rx_got.delete();
          end
        end
      end else if (m_collect) begin
        if (rx_valid) begin
          rx_got.push_back(rx_data);
          silent = 0;
          last_rx_cyc = cyc;
          if (rx_got.size() == 16) begin
            for (int i = 0; i < 16; i++) m_rsp_data[8*i +: 8] = rx_got[i];
            m_collect = 1'b0;
            m_rsp = 1'b1;
          end
        end else begin
          silent++;
          if (silent == T) begin
            m_collect = 1'b0;
            m_to_due = 1'b1;
            m_idle = 1'b1;
          end
        end
      end else if (m_rsp && rsp_ready) begin
        m_rsp = 1'b0;
        m_idle = 1'b1;
      end
    end
  end

  // transmitter ready pattern: 0 always ready, 1 toggling, 2 random
  int tx_mode = 0;
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (tx_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~tx_ready;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_cmd(input logic [127:0] d);
    int budget = 100;
    while (!cmd_ready && budget > 0) begin
      step(1);
      budget--;
    end
    chk("cmd_wait", cmd_ready, 1'b1);
    cmd_data  = d;
    cmd_valid = 1'b1;
    step(1);
    cmd_valid = 1'b0;
    cmd_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic send_rx(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    step(gap);
    rx_data  = b;
    rx_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (rx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    step(1);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    chk("rx_accept", ok, 1'b1);
  endtask

  task automatic take_rsp(input int hold);
    int budget = 100;
    while (!rsp_valid && budget > 0) begin
      step(1);
      budget--;
    end
    chk("rsp_wait", rsp_valid, 1'b1);
    step(hold);
    rsp_ready = 1'b1;
    step(1);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [127:0] d;
    reset_n = 1'b1;
    cmd_valid = 1'b0; cmd_data = '0;
    rx_valid = 1'b0; rx_data = '0;
    rsp_ready = 1'b0;
    #1 reset_n = 1'b0;
    step(3);
    reset_n = 1'b1;
    step(1);
    chk("post_reset_state", debug_state, 2'd0);
`ifdef STL_UART_HOST_TIMEOUT_CNT_EN
    chk("timeout_count_reset", timeout_count, 8'd0);
`endif

    // full-rate command, known response, stalled consumer
    tx_mode = 0;
    tx_log.delete(); tx_hs_cyc.delete();
    do_cmd(128'h0F0E0D0C_0B0A0908_07060504_03020100);
    for (int k = 0; k < 16; k++) send_rx(8'hA0 + 8'(k), 0);
    chk("t1_tx_count", tx_log.size(), 16);
    for (int k = 0; k < 16 && k < tx_log.size(); k++) chk("t1_tx_byte", tx_log[k], 8'(k));
    if (tx_hs_cyc.size() == 16) chk("t1_tx_rate", tx_hs_cyc[15] - tx_hs_cyc[0], 15);
    chk("t1_rsp_valid", rsp_valid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("t1_rsp_hold", rsp_data, 128'hAFAEADAC_ABAAA9A8_A7A6A5A4_A3A2A1A0);
      step(1);
    end
    rsp_ready = 1'b1;
    step(1);
    rsp_ready = 1'b0;
    chk("t1_idle_cmd_ready", cmd_ready, 1'b1);
    chk("t1_idle_state", debug_state, 2'd0);

    // toggling transmitter ready
    tx_mode = 1;
    tx_log.delete(); tx_hs_cyc.delete();
    d = {$urandom, $urandom, $urandom, $urandom};
    do_cmd(d);
    for (int k = 0; k < 16; k++) send_rx(8'($urandom), 0);
    take_rsp(1);
    chk("t2_tx_count", tx_log.size(), 16);
    for (int k = 0; k < 16 && k < tx_log.size(); k++) chk("t2_tx_byte", tx_log[k], d[8*k +: 8]);

    // silence after three bytes times out
    tx_mode = 0;
    to_pulses = 0;
    do_cmd({$urandom, $urandom, $urandom, $urandom});
    for (int k = 0; k < 3; k++) send_rx(8'($urandom), 0);
    step(T + 6);
    chk("t4_pulses", to_pulses, 1);
    chk("t4_delay", pulse_cyc - last_rx_cyc, T + 1);
    chk("t4_state", debug_state, 2'd0);
    chk("t4_cmd_ready", cmd_ready, 1'b1);
`ifdef STL_UART_HOST_TIMEOUT_CNT_EN
    chk("t4_timeout_count", timeout_count, 8'd1);
`endif

    // bytes arriving exactly on the threshold cycle
    to_pulses = 0;
    do_cmd({$urandom, $urandom, $urandom, $urandom});
    for (int k = 0; k < 16; k++) send_rx(8'($urandom), (k == 3 || k == 9) ? T - 1 : 0);
    take_rsp(0);
    chk("t5_no_timeout", to_pulses, 0);

    // randomized packets
    tx_mode = 2;
    for (int p = 0; p < 6; p++) begin
      do_cmd({$urandom, $urandom, $urandom, $urandom});
      for (int k = 0; k < 16; k++) send_rx(8'($urandom), (k == 0) ? 0 : int'($urandom_range(0, T - 1)));
      take_rsp(int'($urandom_range(0, 3)));
    end
    chk("t6_no_timeout", to_pulses, 0);

    // reset in the middle of SEND
    tx_mode = 0;
    tx_log.delete();
    do_cmd({$urandom, $urandom, $urandom, $urandom});
    for (int k = 0; k < 40 && tx_log.size() < 7; k++) step(1);
    chk("t7_mid_send", tx_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("t7_async_tx_valid", tx_valid, 1'b0);
    chk("t7_async_state", debug_state, 2'd0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    step(1);
    chk("t7_cmd_ready", cmd_ready, 1'b1);
    chk("t7_state", debug_state, 2'd0);
`ifdef STL_UART_HOST_TIMEOUT_CNT_EN
    chk("t7_timeout_count", timeout_count, 8'd0);
`endif
    do_cmd({$urandom, $urandom, $urandom, $urandom});
    for (int k = 0; k < 16; k++) send_rx(8'($urandom), 0);
    take_rsp(2);
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
